// File: rtl/somador_serial_if.sv
// Start/busy/done handshake and operand/result bus for the digit-serial adder.
interface somador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             COUT;
  logic             OVF;

  modport master (
    output start, A, B, CIN,
    input  busy, done, S, COUT, OVF
  );

  modport slave (
    input  start, A, B, CIN,
    output busy, done, S, COUT, OVF
  );
endinterface

// File: rtl/somador_serial.sv
// Digit-serial adder: S = A + B + CIN, DIGIT bits per cycle over WIDTH/DIGIT cycles.
// Optional signed overflow flag is enabled by defining SOMADOR_OVF_EN.
module somador_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   somador_serial_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("somador_serial: DIGIT must be >= 1 and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;

   logic [DIGIT:0]   w_sum;
   logic [DIGIT-1:0] w_d;
   logic             w_cn;
   logic             w_last;
   logic [WIDTH-1:0] w_p_next;

   assign w_sum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
   assign w_d    = w_sum[DIGIT-1:0];
   assign w_cn   = w_sum[DIGIT];
   assign w_last = (r_state == RUN) && (r_cnt == LAST);

   // Only the upper WIDTH-DIGIT partial-sum bits need storing; the newest digit
   // goes straight into S on the final edge.
   generate
      if (NDIG > 1) begin : g_psum
         logic [WIDTH-DIGIT-1:0] r_p;
         assign w_p_next = {w_d, r_p};
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_p <= '0;
            else if (r_state == RUN)
               r_p <= w_p_next[WIDTH-1:DIGIT];
         end
      end else begin : g_nopsum
         assign w_p_next = w_d;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  r_a     <= bus.A;
                  r_b     <= bus.B;
                  r_c     <= bus.CIN;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_a   <= r_a >> DIGIT;
               r_b   <= r_b >> DIGIT;
               r_c   <= w_cn;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_s     <= w_p_next;
                  r_cout  <= w_cn;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SOMADOR_OVF_EN
   logic r_ovf;
   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ovf <= 1'b0;
      else if (w_last)
         r_ovf <= r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_d[DIGIT-1] ^ w_cn;
   end
   assign bus.OVF = r_ovf;
`else
   assign bus.OVF = 1'b0;
`endif

   assign bus.busy = (r_state == RUN);
   assign bus.done = (r_state == DONE);
   assign bus.S    = r_s;
   assign bus.COUT = r_cout;
endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial: 8/2 main instance plus 4/4 and 4/1 exhaustive instances.
module tb_somador_serial;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef SOMADOR_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  somador_serial_if #(.WIDTH(8)) bus8 ();
  somador_serial_if #(.WIDTH(4)) bus4a ();
  somador_serial_if #(.WIDTH(4)) bus4b ();

  somador_serial #(.WIDTH(8), .DIGIT(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  somador_serial #(.WIDTH(4), .DIGIT(4)) dut4a (.clk(clk), .rst_n(rst_n), .bus(bus4a));
  somador_serial #(.WIDTH(4), .DIGIT(1)) dut4b (.clk(clk), .rst_n(rst_n), .bus(bus4b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one operation on the 8-bit instance and wait (bounded) for done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     output logic [7:0] s, output logic co, output logic ov,
                     output int edges, output int busyc, output logic both);
    edges = 0; busyc = 0; both = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = a; bus8.B = b; bus8.CIN = cin;
    @(negedge clk);
    edges = 1;
    bus8.start = 1'b0;
    while (!bus8.done && edges < 30) begin
      if (bus8.busy) busyc++;
      @(negedge clk);
      edges++;
    end
    if (bus8.busy && bus8.done) both = 1'b1;
    s = bus8.S; co = bus8.COUT; ov = bus8.OVF;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus8.start = 0;  bus8.A = 0;  bus8.B = 0;  bus8.CIN = 0;
    bus4a.start = 0; bus4a.A = 0; bus4a.B = 0; bus4a.CIN = 0;
    bus4b.start = 0; bus4b.A = 0; bus4b.B = 0; bus4b.CIN = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done, bus8.S, bus8.COUT, bus8.OVF} !== 12'h000) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b S=%h COUT=%b OVF=%b need all 0",
               bus8.busy, bus8.done, bus8.S, bus8.COUT, bus8.OVF);
    end
    checks++;
    if ({bus4a.busy, bus4a.done, bus4a.S, bus4a.COUT, bus4b.busy, bus4b.done, bus4b.S, bus4b.COUT} !== 16'h0) begin
      failures++;
      $display("FAIL reset4 got a:%b%b%h%b b:%b%b%h%b need all 0", bus4a.busy, bus4a.done, bus4a.S,
               bus4a.COUT, bus4b.busy, bus4b.done, bus4b.S, bus4b.COUT);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'h7F};
    logic [7:0] tb [3] = '{8'h3C, 8'h01, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'h96, 8'h00, 8'h80};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic       eo [3] = '{OVF_ON, 1'b0, OVF_ON};
    logic [7:0] s;
    logic co, ov, both;
    int edges, busyc;
    for (int i = 0; i < 3; i++) begin
      op8(ta[i], tb[i], tc[i], s, co, ov, edges, busyc, both);
      checks++;
      if (s !== es[i]) begin failures++; $display("FAIL basic%0d_S got %h need %h", i, s, es[i]); end
      checks++;
      if (co !== ec[i]) begin failures++; $display("FAIL basic%0d_COUT got %b need %b", i, co, ec[i]); end
      checks++;
      if (ov !== eo[i]) begin failures++; $display("FAIL basic%0d_OVF got %b need %b", i, ov, eo[i]); end
      checks++;
      if (edges !== 5) begin failures++; $display("FAIL basic%0d_latency got %0d need 5", i, edges); end
      checks++;
      if (busyc !== 4) begin failures++; $display("FAIL basic%0d_busy_cycles got %0d need 4", i, busyc); end
      checks++;
      if (both !== 1'b0) begin failures++; $display("FAIL basic%0d_busy_and_done got %b need 0", i, both); end
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    logic [7:0] s_first = 8'h00;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'h10; bus8.B = 8'h01; bus8.CIN = 1'b0;
    @(negedge clk);
    bus8.A = 8'hAA; bus8.B = 8'h55;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus8.done) begin
        if (ndone == 0) s_first = bus8.S;
        ndone++;
      end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got %0d need 1", ndone); end
    checks++;
    if (s_first !== 8'h11) begin failures++; $display("FAIL ignore_S got %h need 11", s_first); end
    checks++;
    if (bus8.S !== 8'h11) begin failures++; $display("FAIL ignore_S_hold got %h need 11", bus8.S); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] na [3] = '{8'h01, 8'h03, 8'hF0};
    logic [7:0] nb [3] = '{8'h02, 8'h04, 8'h20};
    logic [7:0] es [3] = '{8'h03, 8'h07, 8'h10};
    int t = 0, last = 0, nd = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = na[0]; bus8.B = nb[0]; bus8.CIN = 1'b0;
    for (int k = 0; k < 40 && nd < 3; k++) begin
      @(negedge clk);
      t++;
      if (bus8.done) begin
        checks++;
        if (bus8.S !== es[nd]) begin failures++; $display("FAIL b2b%0d_S got %h need %h", nd, bus8.S, es[nd]); end
        if (nd > 0) begin
          checks++;
          if (t - last !== 5) begin failures++; $display("FAIL b2b%0d_interval got %0d need 5", nd, t - last); end
        end
        if (nd == 2) begin
          checks++;
          if (bus8.COUT !== 1'b1) begin failures++; $display("FAIL b2b2_COUT got %b need 1", bus8.COUT); end
          bus8.start = 1'b0;
        end else begin
          bus8.A = na[nd+1]; bus8.B = nb[nd+1];
        end
        last = t;
        nd++;
      end
    end
    bus8.start = 1'b0;
    checks++;
    if (nd !== 3) begin failures++; $display("FAIL b2b_timeout got %0d dones need 3", nd); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int ndone = 0;
    logic [7:0] s;
    logic co, ov, both;
    int edges, busyc;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'hAB; bus8.B = 8'h11; bus8.CIN = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b need 0", bus8.busy); end
    checks++;
    if (bus8.S !== 8'h00) begin failures++; $display("FAIL midrst_S got %h need 00", bus8.S); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL midrst_done got %0d pulses need 0", ndone); end
    op8(8'h22, 8'h11, 1'b0, s, co, ov, edges, busyc, both);
    checks++;
    if (s !== 8'h33) begin failures++; $display("FAIL midrst_after_S got %h need 33", s); end
  endtask

  task automatic test_exhaustive;
    int bad_a = 0, bad_b = 0;
    logic [4:0] a, b, c, exp, got_a, got_b;
    logic ga, gb;
    int k;
    for (int v = 0; v < 512; v++) begin
      a = {1'b0, 4'(v >> 5)}; b = {1'b0, 4'(v >> 1)}; c = {4'b0, 1'(v)};
      exp = a + b + c;
      @(negedge clk);
      bus4a.start = 1'b1; bus4a.A = a[3:0]; bus4a.B = b[3:0]; bus4a.CIN = c[0];
      bus4b.start = 1'b1; bus4b.A = a[3:0]; bus4b.B = b[3:0]; bus4b.CIN = c[0];
      @(negedge clk);
      bus4a.start = 1'b0; bus4b.start = 1'b0;
      ga = 1'b0; gb = 1'b0; got_a = '0; got_b = '0; k = 0;
      while (!(ga && gb) && k < 12) begin
        @(negedge clk);
        k++;
        if (bus4a.done && !ga) begin ga = 1'b1; got_a = {bus4a.COUT, bus4a.S}; end
        if (bus4b.done && !gb) begin gb = 1'b1; got_b = {bus4b.COUT, bus4b.S}; end
      end
      checks++;
      if (!ga || got_a !== exp) begin
        failures++; bad_a++;
        if (bad_a < 5) $display("FAIL exh_d4 v=%0d got %h need %h (done=%b)", v, got_a, exp, ga);
      end
      checks++;
      if (!gb || got_b !== exp) begin
        failures++; bad_b++;
        if (bad_b < 5) $display("FAIL exh_d1 v=%0d got %h need %h (done=%b)", v, got_b, exp, gb);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/somador_serial.md
# somador_serial

Parametrised digit-serial adder: the sequential successor of the fixed 4-bit combinational adder. It computes S = A + B + CIN over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle with a registered carry, and trades latency for a narrow DIGIT-bit adder. A start/busy/done handshake lets a controller or testbench issue operands and collect a registered result. With DIGIT = WIDTH it degenerates to a registered single-cycle adder.

## Interface

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 1.
- DIGIT, 2: bits processed per cycle. Must divide WIDTH; elaboration fails otherwise.
- NDIG (localparam) = WIDTH/DIGIT: number of digit cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- A  in  WIDTH  operand A, captured at acceptance.
- B  in  WIDTH  operand B, captured at acceptance.
- CIN  in  1  carry-in, captured at acceptance.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; S, COUT and OVF are valid and hold from this cycle.
- S  out  WIDTH  registered sum.
- COUT  out  1  registered carry-out of bit WIDTH-1.
- OVF  out  1  registered signed overflow; see Configuration.

## Operation

- Internal state: operand shift registers a_sh and b_sh (WIDTH each), carry register c, partial-sum shift register p (WIDTH), digit counter cnt (clog2(NDIG) bits, minimum 1).
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: load a_sh=A, b_sh=B, c=CIN, cnt=0, and go to RUN. With start=0, stay in IDLE.
- RUN, each edge: compute {c', d} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + c as a (DIGIT+1)-bit sum.
  - Shift a_sh and b_sh right by DIGIT.
  - Shift d into p from the MSB side.
  - Update c = c' and increment cnt.
- RUN exit: on the edge where cnt = NDIG-1:
  - Write S = {d, p[WIDTH-1:DIGIT]}, which is the complete sum, and COUT = c'.
  - Set OVF per Configuration and go to DONE.
- DONE: lasts one cycle.
  - With start=1, accept new operands exactly as in IDLE and go to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored; the operation in flight is not disturbed.
- S, COUT and OVF change only at RUN exit and never show partial results. Between operations they hold their last value.
- Arithmetic is unsigned modulo 2^WIDTH. COUT is the unsigned carry; there is no saturation.
- Asserting rst_n low at any time, including mid-RUN, aborts the operation immediately.
  - State goes to IDLE and every register clears to 0.
  - The aborted result is never written, and done does not pulse.

## Timing

- Reset values: busy=0, done=0, S=0, COUT=0, OVF=0, FSM in IDLE.
- Start accepted at edge E0: busy=1 after E0. It falls after edge E0+NDIG, at which point done=1 and S is valid.
- Latency from accepting edge to done is NDIG+1 edges: NDIG digit edges plus the DONE cycle.
- Back-to-back throughput is one operation per NDIG+1 cycles when start is held high, because start is accepted in DONE.
- busy and done are never high together. done is high for exactly one cycle per completed operation.
- A, B and CIN need to be stable only at the accepting edge.

## Configuration

- SOMADOR_OVF_EN defined: OVF is updated at RUN exit as carry-into-MSB XOR carry-out-of-MSB, i.e. the two's-complement overflow of A+B+CIN.
  - The final digit's internal MSB carry is used.
  - When DIGIT=1, this is c before the last edge XOR c'.
- SOMADOR_OVF_EN undefined: the OVF port remains but is tied to 0. No overflow logic is synthesised.

## Test plan

- WIDTH=8, DIGIT=2, SOMADOR_OVF_EN defined:
  - A=0x5A, B=0x3C, CIN=0 -> after 5 edges: done pulse, S=0x96, COUT=0, OVF=1; busy high for exactly 4 cycles.
  - A=0xFF, B=0x01, CIN=0 -> S=0x00, COUT=1, OVF=0. A=0x7F, B=0x00, CIN=1 -> S=0x80, COUT=0, OVF=1. Without the macro, OVF stays 0 for both.
- Apply start with A=0x10, B=0x01, then during RUN apply start with A=0xAA, B=0x55 -> single done, S=0x11. The second request is ignored; S holds 0x11 afterwards.
- Hold start=1 for three operations (0x01+0x02, 0x03+0x04, 0xF0+0x20) -> done pulses every 5 cycles with S = 0x03, 0x07, then 0x10 with COUT=1.
- Drive rst_n low for 1 cycle at cnt=2 mid-RUN -> immediately busy=0 and S=0, no done pulse; a following 0x22+0x11 gives S=0x33.
- WIDTH=4, DIGIT=4 and WIDTH=4, DIGIT=1: exhaustive 512 vectors of {A, B, CIN} -> S and COUT equal to the 5-bit A+B+CIN on every done, zero mismatches reported.
